// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine transaction sequencer:
// state encoding, product codes, list prices and the accepted coin set.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT_DONE,
    ST_WINDOW,
    ST_LATCH,
    ST_PAY,
    ST_DISPENSE,
    ST_REFUND
  } state_e;

  localparam logic [1:0] PROD_A = 2'b01;
  localparam logic [1:0] PROD_B = 2'b10;
  localparam logic [1:0] PROD_C = 2'b11;

  localparam logic [4:0] PRICE_A = 5'd15;
  localparam logic [4:0] PRICE_B = 5'd20;
  localparam logic [4:0] PRICE_C = 5'd25;

  localparam logic [4:0] COIN_5  = 5'd5;
  localparam logic [4:0] COIN_10 = 5'd10;
  localparam logic [4:0] COIN_20 = 5'd20;

  localparam logic [7:0] SEL_WINDOW_DEF  = 8'd100;
  localparam logic [7:0] PAY_TIMEOUT_DEF = 8'd200;
  localparam logic [5:0] CREDIT_MAX_DEF  = 6'd63;

  function automatic logic coin_denom_ok(input logic [4:0] value);
    return (value == COIN_5) || (value == COIN_10) || (value == COIN_20);
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; stops at zero and reports both the current and the
// upcoming zero condition so callers can register a flag for the zero cycle.
module vend_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o,
  output logic         zero_next_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)                        count_d = load_val_i;
    else if (dec_i && count_q != '0)   count_d = count_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o     = count_q;
  assign zero_o      = (count_q == '0);
  assign zero_next_o = (count_d == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: selector handshake, price capture, coin
// credit, dispense and change. Every output is driven straight from a flop.
module vend_controller
  import vend_pkg::*;
#(
  parameter logic [7:0] SEL_WINDOW  = SEL_WINDOW_DEF,
  parameter logic [7:0] PAY_TIMEOUT = PAY_TIMEOUT_DEF,
  parameter logic [5:0] CREDIT_MAX  = CREDIT_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cancel,
  input  logic       coin_valid,
  input  logic [4:0] coin_value,
  input  logic       sel_done,
  input  logic [4:0] sel_price,
  input  logic [1:0] sel_product,
  output logic       sel_en,
  output logic       sel_timeout,
  output logic [5:0] credit,
  output logic       coin_reject,
  output logic       dispense_valid,
  output logic [1:0] dispense_product,
  output logic       change_valid,
  output logic [5:0] change_amount,
  output logic       invalid_sel,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [5:0] credit_q, credit_d;
  logic [4:0] price_q, price_d;
  logic [1:0] product_q, product_d;
  logic       sel_en_q, sel_en_d, sel_timeout_q, sel_timeout_d;
  logic       coin_reject_q, coin_reject_d, invalid_q, invalid_d, busy_q, busy_d;
  logic       disp_valid_q, disp_valid_d, change_valid_q, change_valid_d;
  logic [1:0] disp_prod_q, disp_prod_d;
  logic [5:0] change_amt_q, change_amt_d;

  logic       win_load, win_dec, win_zero, win_zero_next;
  logic       pay_load, pay_dec, pay_zero;
  logic [7:0] win_count, pay_count;
  logic [6:0] coin_sum;
  logic       coin_ok;

  vend_timer #(.W(8)) u_win_timer (
    .clk(clk), .rst_n(rst_n), .load_i(win_load), .load_val_i(SEL_WINDOW - 8'd1),
    .dec_i(win_dec), .count_o(win_count), .zero_o(win_zero), .zero_next_o(win_zero_next)
  );

  // Idle timer counts down from PAY_TIMEOUT-1; its zero cycle is the
  // PAY_TIMEOUT-th consecutive PAY cycle without an accepted coin.
  vend_timer #(.W(8)) u_pay_timer (
    .clk(clk), .rst_n(rst_n), .load_i(pay_load), .load_val_i(PAY_TIMEOUT - 8'd1),
    .dec_i(pay_dec), .count_o(pay_count), .zero_o(pay_zero), .zero_next_o()
  );

  assign coin_sum = {1'b0, credit_q} + {2'b00, coin_value};
  assign coin_ok  = coin_valid && coin_denom_ok(coin_value) && (coin_sum <= {1'b0, CREDIT_MAX});

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    price_d       = price_q;
    product_d     = product_q;
    win_load      = 1'b0;
    win_dec       = 1'b0;
    pay_load      = 1'b0;
    pay_dec       = 1'b0;
    invalid_d     = 1'b0;
    coin_reject_d = coin_valid && (state_q != ST_PAY);

    case (state_q)
      ST_IDLE:      if (start) state_d = ST_SELECT;
      ST_SELECT:    state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (sel_done) begin
                      win_load = 1'b1;
                      state_d  = ST_WINDOW;
                    end
      ST_WINDOW:    if (win_zero) state_d = ST_LATCH;
                    else          win_dec = 1'b1;
      ST_LATCH: begin
        price_d   = sel_price;
        product_d = sel_product;
        if (sel_price == 5'd0) begin
          invalid_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          pay_load = 1'b1;
          state_d  = ST_PAY;
        end
      end
      ST_PAY: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          state_d       = ST_REFUND;
        end else if (coin_ok) begin
          credit_d = coin_sum[5:0];
          pay_load = 1'b1;
          if (coin_sum >= {2'b00, price_q}) state_d = ST_DISPENSE;
        end else begin
          coin_reject_d = coin_valid;
          if (pay_zero) state_d = ST_REFUND;
          else          pay_dec = 1'b1;
        end
      end
      ST_DISPENSE: begin
        credit_d = credit_q - {1'b0, price_q};
        state_d  = ST_REFUND;
      end
      ST_REFUND: begin
        credit_d = 6'd0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pulses are registered for the cycle the machine spends in the target state.
    disp_valid_d   = (state_d == ST_DISPENSE);
    disp_prod_d    = disp_valid_d ? product_q : disp_prod_q;
    change_valid_d = (state_d == ST_REFUND) && (credit_d != 6'd0);
    change_amt_d   = change_valid_d ? credit_d : change_amt_q;
    sel_en_d       = (state_d == ST_SELECT);
    sel_timeout_d  = (state_d == ST_WINDOW) && win_zero_next;
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      price_q        <= '0;
      product_q      <= '0;
      sel_en_q       <= 1'b0;
      sel_timeout_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      invalid_q      <= 1'b0;
      busy_q         <= 1'b0;
      disp_valid_q   <= 1'b0;
      disp_prod_q    <= '0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      price_q        <= price_d;
      product_q      <= product_d;
      sel_en_q       <= sel_en_d;
      sel_timeout_q  <= sel_timeout_d;
      coin_reject_q  <= coin_reject_d;
      invalid_q      <= invalid_d;
      busy_q         <= busy_d;
      disp_valid_q   <= disp_valid_d;
      disp_prod_q    <= disp_prod_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
    end
  end

  assign sel_en           = sel_en_q;
  assign sel_timeout      = sel_timeout_q;
  assign credit           = credit_q;
  assign coin_reject      = coin_reject_q;
  assign dispense_valid   = disp_valid_q;
  assign dispense_product = disp_prod_q;
  assign change_valid     = change_valid_q;
  assign change_amount    = change_amt_q;
  assign invalid_sel      = invalid_q;
  assign busy             = busy_q;

endmodule
